phase_scheduler: RTL and testbench

Round-robin scheduler that shares the intersection between N traffic phases (NS, east left+straight, west left+straight, E/W straight pair, E/W left pair). Latches sensor requests, grants one phase at a time to the light sequencer over a valid/ready handshake, and times the green with a gap-out timer and a max-green timer. Sits between the sensor inputs and the light sequencer FSM; the sequencer owns the yellow and all-red timing, and this block owns the phase choice and green termination.

---
 rtl/phase_scheduler.sv | 173 +++++++++++++++++
 tb/tb_phase_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_scheduler.sv
// Round-robin traffic phase scheduler: latches sensor requests, offers one phase
// at a time to the light sequencer and ends its green on gap-out or max-out.
// Optional emergency preemption is compiled in with `define PREEMPT_EN.
module phase_scheduler #(
    parameter int N_PHASES   = 5,
    parameter int GAP_CYCLES = 5,
    parameter int MAX_CYCLES = 10,
    parameter int CTR_W      = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_PHASES-1:0]           req,
    input  logic                          seq_ready,
    input  logic                          seq_done,
`ifdef PREEMPT_EN
    input  logic                          preempt,
    input  logic [$clog2(N_PHASES)-1:0]   preempt_phase,
`endif
    output logic [N_PHASES-1:0]           grant,
    output logic                          grant_valid,
    output logic                          terminate,
    output logic [$clog2(N_PHASES)-1:0]   active_phase,
    output logic [N_PHASES-1:0]           pending
);

    localparam int IDX_W = $clog2(N_PHASES);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        GREEN,
        TERM,
        WAIT_DONE
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [CTR_W-1:0]   gap_ctr;
    logic [CTR_W-1:0]   max_ctr;
    logic               preempt_grant;

    logic               rr_found;
    logic [IDX_W-1:0]   rr_idx;
    logic [IDX_W-1:0]   cand;
    logic               serving;
    logic               handshake;
    logic [N_PHASES-1:0] pending_next;
    logic               gap_out;
    logic               max_out;
    logic               preempt_ok;
    logic               preempt_other;
    logic               hold_green;
    logic               sel_valid;
    logic [IDX_W-1:0]   sel_idx;
    logic               green_end;

    function automatic logic [N_PHASES-1:0] to_onehot(input logic [IDX_W-1:0] idx);
        to_onehot      = '0;
        to_onehot[idx] = 1'b1;
    endfunction

    // Search starts just past the last served phase so every phase gets a turn.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int k = 1; k <= N_PHASES; k++) begin
            cand = IDX_W'((int'(ptr) + k) % N_PHASES);
            if (!rr_found && pending[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    assign serving   = (state == GREEN) || (state == TERM) || (state == WAIT_DONE);
    assign handshake = (state == ISSUE) && grant_valid && seq_ready;

    // The phase being served does not re-request itself; a grant clears its own bit.
    assign pending_next = (pending | (req & ~(serving ? grant : {N_PHASES{1'b0}})))
                        & ~(handshake ? grant : {N_PHASES{1'b0}});

    assign gap_out = (gap_ctr == CTR_W'(GAP_CYCLES));
    assign max_out = (max_ctr == CTR_W'(MAX_CYCLES)) && (|(pending & ~grant));

`ifdef PREEMPT_EN
    assign preempt_ok    = preempt && (int'(preempt_phase) < N_PHASES);
    assign preempt_other = preempt_ok && (preempt_phase != active_phase);
    assign hold_green    = preempt_ok && (preempt_phase == active_phase);
    assign sel_idx       = preempt_ok ? preempt_phase : rr_idx;
`else
    assign preempt_ok    = 1'b0;
    assign preempt_other = 1'b0;
    assign hold_green    = 1'b0;
    assign sel_idx       = rr_idx;
`endif

    assign sel_valid = preempt_ok || rr_found;
    assign green_end = preempt_other || (gap_out && !hold_green) || max_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            grant         <= '0;
            grant_valid   <= 1'b0;
            terminate     <= 1'b0;
            active_phase  <= '0;
            pending       <= '0;
            ptr           <= IDX_W'(N_PHASES - 1);
            gap_ctr       <= '0;
            max_ctr       <= '0;
            preempt_grant <= 1'b0;
        end else begin
            pending   <= pending_next;
            terminate <= 1'b0;
            unique case (state)
                IDLE: begin
                    grant       <= '0;
                    grant_valid <= 1'b0;
                    if (sel_valid) begin
                        grant         <= to_onehot(sel_idx);
                        active_phase  <= sel_idx;
                        grant_valid   <= 1'b1;
                        preempt_grant <= preempt_ok;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (seq_ready) begin
                        grant_valid <= 1'b0;
                        if (!preempt_grant) begin
                            ptr <= active_phase;
                        end
                        gap_ctr <= '0;
                        max_ctr <= '0;
                        state   <= GREEN;
                    end
                end
                GREEN: begin
                    if (max_ctr != CTR_W'(MAX_CYCLES)) begin
                        max_ctr <= max_ctr + 1'b1;
                    end
                    if (req[active_phase]) begin
                        gap_ctr <= '0;
                    end else if (gap_ctr != CTR_W'(GAP_CYCLES)) begin
                        gap_ctr <= gap_ctr + 1'b1;
                    end
                    // A sequencer abort wins over any termination decision.
                    if (seq_done) begin
                        grant <= '0;
                        state <= IDLE;
                    end else if (green_end) begin
                        terminate <= 1'b1;
                        state     <= TERM;
                    end
                end
                TERM: begin
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (seq_done) begin
                        grant <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phase_scheduler.sv
// Scoreboard bench for phase_scheduler: directed stimulus pushes expected grant offers
// and terminate pulses with their cycle numbers; a negedge monitor pops and compares.
module tb_phase_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] req;
    logic       seq_ready;
    logic       seq_done;
    logic [4:0] grant;
    logic       grant_valid;
    logic       terminate;
    logic [2:0] active_phase;
    logic [4:0] pending;

    phase_scheduler #(
        .N_PHASES  (5),
        .GAP_CYCLES(5),
        .MAX_CYCLES(10),
        .CTR_W     (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .seq_ready   (seq_ready),
        .seq_done    (seq_done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .terminate   (terminate),
        .active_phase(active_phase),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      tag;
        bit         is_term;
        logic [4:0] grant;
        logic [2:0] phase;
        int         at;
    } exp_t;

    exp_t sb[$];
    bit   gv_prev = 1'b0;

    function automatic void checkOutput(input string name, input int act, input int req_val);
        total++;
        if (act != req_val) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req_val, cyc);
        end
    endfunction

    function automatic void expectEvent(input string tag, input bit is_term,
                                        input logic [4:0] g, input logic [2:0] ph, input int at);
        exp_t e;
        e.tag     = tag;
        e.is_term = is_term;
        e.grant   = g;
        e.phase   = ph;
        e.at      = at;
        sb.push_back(e);
    endfunction

    function automatic void scoreEvent(input bit is_term);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_event: actual term=%0d grant=%b at cycle %0d, required none",
                     is_term, grant, cyc);
        end else begin
            e = sb.pop_front();
            checkOutput({e.tag, "_kind"}, int'(is_term), int'(e.is_term));
            checkOutput({e.tag, "_grant"}, int'(grant), int'(e.grant));
            if (!is_term) checkOutput({e.tag, "_phase"}, int'(active_phase), int'(e.phase));
            checkOutput({e.tag, "_cycle"}, cyc, e.at);
        end
    endfunction

    // Monitor: a new grant offer or a terminate pulse is an observable event.
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            gv_prev <= 1'b0;
        end else begin
            if (grant_valid && !gv_prev) scoreEvent(1'b0);
            if (terminate) scoreEvent(1'b1);
            gv_prev <= grant_valid;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [4:0] r, input logic rdy, input logic done);
        req       = r;
        seq_ready = rdy;
        seq_done  = done;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;
        exp_t e;
        reset = 1'b0;
        applyStimulus(5'b00000, 1'b0, 1'b0);
        tick(3);
        checkOutput("rst_grant", int'(grant), 0);
        checkOutput("rst_valid", int'(grant_valid), 0);
        checkOutput("rst_term", int'(terminate), 0);
        checkOutput("rst_active", int'(active_phase), 0);
        checkOutput("rst_pending", int'(pending), 0);
        reset = 1'b1;
        tick(1);

        // One-cycle request on phase 0, then gap-out with no traffic.
        $display("[TB] single request and gap-out");
        c = cyc;
        applyStimulus(5'b00001, 1'b1, 1'b0);
        expectEvent("t1_offer", 1'b0, 5'b00001, 3'd0, c + 2);
        expectEvent("t1_gapout", 1'b1, 5'b00001, 3'd0, c + 9);
        tick(1);
        applyStimulus(5'b00000, 1'b1, 1'b0);
        tick(2);
        checkOutput("t1_pending_cleared", int'(pending), 0);
        checkOutput("t1_grant_green", int'(grant), 'b00001);
        checkOutput("t1_valid_dropped", int'(grant_valid), 0);
        checkOutput("t1_active", int'(active_phase), 0);
        tick(8);
        checkOutput("t1_grant_wait", int'(grant), 'b00001);
        checkOutput("t1_term_single", int'(terminate), 0);
        applyStimulus(5'b00000, 1'b1, 1'b1);
        tick(1);
        checkOutput("t1_grant_done", int'(grant), 0);
        applyStimulus(5'b00000, 1'b1, 1'b0);

        // Traffic held, then dropped: gap-out six cycles after the drop.
        $display("[TB] gap-out after traffic drop");
        c = cyc;
        applyStimulus(5'b00001, 1'b1, 1'b0);
        expectEvent("t2_offer", 1'b0, 5'b00001, 3'd0, c + 2);
        tick(6);
        applyStimulus(5'b00000, 1'b1, 1'b0);
        expectEvent("t2_gapout", 1'b1, 5'b00001, 3'd0, c + 12);
        tick(7);
        applyStimulus(5'b00000, 1'b1, 1'b1);
        tick(1);
        applyStimulus(5'b00000, 1'b1, 1'b0);
        checkOutput("t2_grant_done", int'(grant), 0);

        // Max-out with a competing phase 2, then sequencer abort of phase 2.
        $display("[TB] max-out and abort");
        c = cyc;
        applyStimulus(5'b00001, 1'b1, 1'b0);
        expectEvent("t3_offer0", 1'b0, 5'b00001, 3'd0, c + 2);
        expectEvent("t3_maxout", 1'b1, 5'b00001, 3'd0, c + 14);
        tick(2);
        applyStimulus(5'b00101, 1'b1, 1'b0);
        tick(1);
        checkOutput("t3_pending", int'(pending), 'b00100);
        tick(11);
        applyStimulus(5'b00000, 1'b1, 1'b0);
        expectEvent("t3_offer2", 1'b0, 5'b00100, 3'd2, c + 17);
        tick(1);
        applyStimulus(5'b00000, 1'b1, 1'b1);
        tick(1);
        applyStimulus(5'b00000, 1'b1, 1'b0);
        tick(2);
        applyStimulus(5'b00000, 1'b1, 1'b1);
        tick(1);
        applyStimulus(5'b00000, 1'b1, 1'b0);
        checkOutput("t3_abort_grant", int'(grant), 0);
        checkOutput("t3_abort_pending", int'(pending), 0);

        // Wrap-around order with pending 10011 and pointer at phase 0.
        $display("[TB] round-robin wrap");
        c = cyc;
        applyStimulus(5'b00001, 1'b1, 1'b0);
        expectEvent("t4_offer0", 1'b0, 5'b00001, 3'd0, c + 2);
        tick(2);
        applyStimulus(5'b00000, 1'b1, 1'b0);
        tick(1);
        applyStimulus(5'b10010, 1'b1, 1'b0);
        tick(1);
        applyStimulus(5'b00000, 1'b1, 1'b1);
        tick(1);
        applyStimulus(5'b00001, 1'b1, 1'b0);
        expectEvent("t4_rr_first", 1'b0, 5'b00010, 3'd1, c + 6);
        tick(1);
        applyStimulus(5'b00000, 1'b1, 1'b0);
        tick(1);
        checkOutput("t4_pending", int'(pending), 'b10001);
        applyStimulus(5'b00000, 1'b1, 1'b1);
        tick(1);
        applyStimulus(5'b00000, 1'b1, 1'b0);
        expectEvent("t4_rr_second", 1'b0, 5'b10000, 3'd4, c + 9);
        tick(2);
        applyStimulus(5'b00000, 1'b1, 1'b1);
        tick(1);
        applyStimulus(5'b00000, 1'b1, 1'b0);
        expectEvent("t4_rr_wrap", 1'b0, 5'b00001, 3'd0, c + 12);
        tick(2);
        applyStimulus(5'b00000, 1'b1, 1'b1);
        tick(1);
        applyStimulus(5'b00000, 1'b1, 1'b0);
        checkOutput("t4_pending_empty", int'(pending), 0);

        // Sequencer not ready: offer holds, other requests keep latching.
        $display("[TB] issue stall");
        c = cyc;
        applyStimulus(5'b01000, 1'b0, 1'b0);
        expectEvent("t5_offer3", 1'b0, 5'b01000, 3'd3, c + 2);
        tick(2);
        applyStimulus(5'b01110, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t5_hold_valid", int'(grant_valid), 1);
            checkOutput("t5_hold_grant", int'(grant), 'b01000);
            if (i == 1) applyStimulus(5'b01000, 1'b0, 1'b0);
            if (i == 3) applyStimulus(5'b01000, 1'b1, 1'b0);
            tick(1);
        end
        checkOutput("t5_pending_kept", int'(pending), 'b00110);
        checkOutput("t5_valid_dropped", int'(grant_valid), 0);
        applyStimulus(5'b00000, 1'b1, 1'b1);
        expectEvent("t5_offer1", 1'b0, 5'b00010, 3'd1, c + 8);
        tick(1);
        applyStimulus(5'b00000, 1'b1, 1'b0);
        tick(2);
        applyStimulus(5'b00000, 1'b1, 1'b1);
        expectEvent("t5_offer2", 1'b0, 5'b00100, 3'd2, c + 11);
        tick(1);
        applyStimulus(5'b00000, 1'b1, 1'b0);
        tick(2);
        applyStimulus(5'b00000, 1'b1, 1'b1);
        tick(1);
        applyStimulus(5'b00000, 1'b1, 1'b0);

        // Asynchronous reset while waiting for the sequencer.
        $display("[TB] reset during wait");
        c = cyc;
        applyStimulus(5'b01000, 1'b1, 1'b0);
        expectEvent("t6_offer3", 1'b0, 5'b01000, 3'd3, c + 2);
        expectEvent("t6_gapout", 1'b1, 5'b01000, 3'd3, c + 9);
        tick(1);
        applyStimulus(5'b00000, 1'b1, 1'b0);
        tick(9);
        applyStimulus(5'b00100, 1'b1, 1'b0);
        tick(1);
        applyStimulus(5'b00000, 1'b1, 1'b0);
        checkOutput("t6_pending_before", int'(pending), 'b00100);
        checkOutput("t6_grant_before", int'(grant), 'b01000);
        checkOutput("t6_active_before", int'(active_phase), 3);
        #2 reset = 1'b0;
        #1;
        checkOutput("t6_rst_grant", int'(grant), 0);
        checkOutput("t6_rst_valid", int'(grant_valid), 0);
        checkOutput("t6_rst_term", int'(terminate), 0);
        checkOutput("t6_rst_active", int'(active_phase), 0);
        checkOutput("t6_rst_pending", int'(pending), 0);
        tick(1);
        reset = 1'b1;
        c = cyc;
        applyStimulus(5'b10001, 1'b1, 1'b0);
        expectEvent("t6_post_rst", 1'b0, 5'b00001, 3'd0, c + 2);
        tick(1);
        applyStimulus(5'b00000, 1'b1, 1'b0);
        tick(2);
        applyStimulus(5'b00000, 1'b1, 1'b1);
        expectEvent("t6_post_next", 1'b0, 5'b10000, 3'd4, c + 5);
        tick(1);
        applyStimulus(5'b00000, 1'b1, 1'b0);
        tick(2);
        applyStimulus(5'b00000, 1'b1, 1'b1);
        tick(1);
        applyStimulus(5'b00000, 1'b1, 1'b0);
        tick(3);

        while (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            bad++;
            $display("[TB] FAIL missing_%s: actual none, required grant=%b at cycle %0d",
                     e.tag, e.grant, e.at);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
